// File: rtl/periph_bus_master.sv
// ---------------------------------------------------------------------------
// periph_bus_master
//
// Purpose: queues register read/write commands in a small FIFO and executes
// them one at a time on a simple peripheral bus (separate write and read
// strobes). Each command produces exactly one response, in acceptance order.
// Word-misaligned addresses are rejected with an error response and never
// reach the bus.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cmd_*             command channel (valid/ready), we=1 write / we=0 read
//   rsp_*             response channel (valid/ready), rdata and err
//   waddr_o, data_o,
//   sel_o, we_o       peripheral write channel (one-cycle strobe)
//   raddr_o, rd_o,
//   data_i            peripheral read channel; data_i is valid the cycle
//                     after rd_o was sampled high
// ---------------------------------------------------------------------------
module periph_bus_master #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [7:0]  cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [7:0]  waddr_o,
  output logic [31:0] data_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic [7:0]  raddr_o,
  output logic        rd_o,
  input  logic [31:0] data_i
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CMD_W = 1 + 8 + 32 + 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_RDW  = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Command FIFO
  logic [CMD_W-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [CMD_W-1:0] w_push_word;
  logic [CMD_W-1:0] w_head;
  logic             w_head_we;
  logic [7:0]       w_head_addr;
  logic [31:0]      w_head_wdata;
  logic [3:0]       w_head_sel;
  logic             w_head_misaligned;

  // Command being executed and its response
  logic [7:0]  r_cmd_addr;
  logic [31:0] r_cmd_wdata;
  logic [3:0]  r_cmd_sel;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // Gated by rst so the port reads 0 for the whole reset interval, while the
  // registered count is already 0 (not full).
  assign cmd_ready_o = ~rst & ~w_full;
  assign w_push      = cmd_valid_i & cmd_ready_o;
  assign w_pop       = (r_state == S_IDLE) & ~w_empty;

  assign w_push_word = {cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_sel_i};
  assign w_head      = r_fifo_mem[r_rptr];
  assign w_head_we         = w_head[CMD_W-1];
  assign w_head_addr       = w_head[CMD_W-2 -: 8];
  assign w_head_wdata      = w_head[35:4];
  assign w_head_sel        = w_head[3:0];
  assign w_head_misaligned = (w_head_addr[1:0] != 2'b00);

  // Storage array carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wptr] <= w_push_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          if (w_head_misaligned) begin
            w_state_next = S_RSP;
          end else if (w_head_we) begin
            w_state_next = S_WR;
          end else begin
            w_state_next = S_RD;
          end
        end
      end
      S_WR:  w_state_next = S_RSP;
      S_RD:  w_state_next = S_RDW;
      S_RDW: w_state_next = S_RSP;
      S_RSP: begin
        if (rsp_ready_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Command and response registers. The response is pre-set when the command
  // is popped (zero data, error flag from alignment); reads then overwrite the
  // data in RDW. Nothing changes while parked in RSP, so the response holds
  // steady under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_sel   <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_cmd_addr  <= w_head_addr;
        r_cmd_wdata <= w_head_wdata;
        r_cmd_sel   <= w_head_sel;
        r_rsp_rdata <= '0;
        r_rsp_err   <= w_head_misaligned;
      end else if (r_state == S_RDW) begin
        r_rsp_rdata <= data_i;
        r_rsp_err   <= 1'b0;
      end
    end
  end

  // FSM: outputs. Bus fields are forced to zero whenever their strobe is low.
  always_comb begin
    we_o        = 1'b0;
    waddr_o     = '0;
    data_o      = '0;
    sel_o       = '0;
    rd_o        = 1'b0;
    raddr_o     = '0;
    rsp_valid_o = 1'b0;
    case (r_state)
      S_WR: begin
        we_o    = 1'b1;
        waddr_o = r_cmd_addr;
        data_o  = r_cmd_wdata;
        sel_o   = r_cmd_sel;
      end
      S_RD: begin
        rd_o    = 1'b1;
        raddr_o = r_cmd_addr;
      end
      S_RSP: begin
        rsp_valid_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

endmodule
